// File: rtl/shiftregister_universal.sv
// shiftregister_universal: universal shift register with single-step operation and counted bursts.
// A burst latches mode, load value and count; serial inputs stay live while it runs.
module shiftregister_universal #(
    parameter int WIDTH       = 5,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clockpulse,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   serial_in_msb,
    input  logic                   serial_in_lsb,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] step_count,
    output logic [WIDTH-1:0]       signal_q,
    output logic [WIDTH-1:0]       signal_q_,
    output logic                   serial_out_msb,
    output logic                   serial_out_lsb,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       reg_q, reg_d, data_q, data_d;
    logic [2:0]             mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;

    function automatic logic [WIDTH-1:0] apply(input logic [2:0] op, input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] d);
        case (op)
            3'b001:  apply = {serial_in_msb, q[WIDTH-1:1]};
            3'b010:  apply = {q[WIDTH-2:0], serial_in_lsb};
            3'b011:  apply = {q[0], q[WIDTH-1:1]};
            3'b100:  apply = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101:  apply = d;
            3'b110:  apply = {q[WIDTH-1], q[WIDTH-1:1]};
            3'b111:  apply = '0;
            default: apply = q;
        endcase
    endfunction

    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            reg_q   <= '0;
            data_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (start && step_count != '0) ? BURST : IDLE;
        else if (cnt_q == COUNT_WIDTH'(1))
            state_d = IDLE;
    end

    // A zero-count start never leaves IDLE but still reports completion.
    always_comb begin
        reg_d  = reg_q;
        data_d = data_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (state_q == BURST) begin
            reg_d  = apply(mode_q, reg_q, data_q);
            cnt_d  = cnt_q - COUNT_WIDTH'(1);
            done_d = cnt_q == COUNT_WIDTH'(1);
        end else if (start) begin
            data_d = load_data;
            mode_d = mode;
            cnt_d  = step_count;
            done_d = step_count == '0;
        end else if (enable) begin
            reg_d = apply(mode, reg_q, load_data);
        end
    end

    always_comb begin
        signal_q       = reg_q;
        signal_q_      = ~reg_q;
        serial_out_msb = reg_q[WIDTH-1];
        serial_out_lsb = reg_q[0];
        busy           = state_q == BURST;
        done           = done_q;
    end
endmodule

// File: tb/tb_shiftregister_universal.sv
// tb_shiftregister_universal: directed test of shiftregister_universal against an arithmetic model.
// The model tracks register value, burst progress and done pulse; literal checks pin key points.
module tb_shiftregister_universal;
    localparam int W   = 5;
    localparam int CW  = 4;
    localparam int TOP = 1 << (W - 1);
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    mode = '0;
    logic [W-1:0]  load_data = '0;
    logic          serial_in_msb = 1'b0;
    logic          serial_in_lsb = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] step_count = '0;
    logic [W-1:0]  signal_q, signal_q_;
    logic          serial_out_msb, serial_out_lsb, busy, done;

    int checks = 0;
    int failures = 0;

    int m_q = 0, m_rem = 0, m_mode = 0, m_data = 0;
    bit m_busy = 1'b0, m_done = 1'b0;

    shiftregister_universal #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clockpulse(clk), .clear(clear), .enable(enable), .mode(mode), .load_data(load_data),
        .serial_in_msb(serial_in_msb), .serial_in_lsb(serial_in_lsb), .start(start),
        .step_count(step_count), .signal_q(signal_q), .signal_q_(signal_q_),
        .serial_out_msb(serial_out_msb), .serial_out_lsb(serial_out_lsb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int op(input int md, input int q, input int d);
        case (md)
            1:       return (q >> 1) + (serial_in_msb ? TOP : 0);
            2:       return (q * 2) % MOD + int'(serial_in_lsb);
            3:       return (q >> 1) + (q % 2) * TOP;
            4:       return (q * 2) % MOD + q / TOP;
            5:       return d;
            6:       return (q >> 1) + (q >= TOP ? TOP : 0);
            7:       return 0;
            default: return q;
        endcase
    endfunction

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_q = 0; m_rem = 0; m_mode = 0; m_data = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_q = op(m_mode, m_q, m_data);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; m_done = 1; end
            end else if (start) begin
                m_mode = int'(mode); m_data = int'(load_data); m_rem = int'(step_count);
                if (m_rem == 0) m_done = 1; else m_busy = 1;
            end else if (enable) begin
                m_q = op(int'(mode), m_q, int'(load_data));
            end
        end
    end

    always @(negedge clk) begin
        chk("model_q", 32'(signal_q), 32'(m_q));
        chk("model_qn", 32'(signal_q_), 32'((~m_q) & (MOD - 1)));
        chk("model_so_msb", 32'(serial_out_msb), 32'(m_q / TOP));
        chk("model_so_lsb", 32'(serial_out_lsb), 32'(m_q % 2));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(done), 32'(m_done));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic st, input logic [2:0] md,
                         input logic [W-1:0] ld, input logic [CW-1:0] cnt);
        enable = en; start = st; mode = md; load_data = ld; step_count = cnt;
        tick();
    endtask

    task automatic pulse_clear(input string nm);
        #2 clear = 1'b1;
        #1;
        chk({nm, "_q"}, 32'(signal_q), 32'h00);
        chk({nm, "_qn"}, 32'(signal_q_), 32'h1f);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_done"}, 32'(done), 32'h0);
        #1 clear = 1'b0;
    endtask

    logic [W-1:0] rot_exp [5] = '{5'b11001, 5'b11100, 5'b01110, 5'b00111, 5'b10011};

    initial begin
        #1 clear = 1'b1;
        #11 clear = 1'b0;
        @(negedge clk);
        drive(1, 0, 3'b101, 5'b10011, 0);
        chk("load", 32'(signal_q), 32'b10011);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 3'b011, 5'b00000, 0);
            chk($sformatf("rotr%0d", i), 32'(signal_q), 32'(rot_exp[i]));
        end
        pulse_clear("reset");
        drive(1, 0, 3'b101, 5'b10110, 0);
        drive(1, 0, 3'b110, 5'b00000, 0);
        chk("asr", 32'(signal_q), 32'b11011);
        drive(1, 0, 3'b101, 5'b10110, 0);
        serial_in_msb = 1'b0;
        drive(1, 0, 3'b001, 5'b00000, 0);
        chk("lsr", 32'(signal_q), 32'b01011);
        drive(1, 0, 3'b101, 5'b10110, 0);
        serial_in_lsb = 1'b1;
        drive(1, 0, 3'b010, 5'b00000, 0);
        chk("shl", 32'(signal_q), 32'b01101);
        drive(0, 0, 3'b101, 5'b11111, 0);
        chk("hold_en0", 32'(signal_q), 32'b01101);
        drive(1, 0, 3'b000, 5'b11111, 0);
        chk("hold_mode0", 32'(signal_q), 32'b01101);
        drive(1, 0, 3'b111, 5'b11111, 0);
        chk("zero", 32'(signal_q), 32'b00000);
        // burst of rotate-left with distracting inputs
        drive(1, 0, 3'b101, 5'b00001, 0);
        drive(1, 1, 3'b100, 5'b11111, 3);
        chk("b_acc_q", 32'(signal_q), 32'b00001);
        chk("b_acc_busy", 32'(busy), 32'h1);
        drive(1, 1, 3'b111, 5'b11111, 0);
        chk("b1_q", 32'(signal_q), 32'b00010);
        drive(1, 0, 3'b101, 5'b11111, 0);
        chk("b2_q", 32'(signal_q), 32'b00100);
        chk("b2_busy", 32'(busy), 32'h1);
        drive(0, 1, 3'b111, 5'b11111, 0);
        chk("b3_q", 32'(signal_q), 32'b01000);
        chk("b3_busy", 32'(busy), 32'h0);
        chk("b3_done", 32'(done), 32'h1);
        // start during the done cycle; 5 rotates restore q
        drive(0, 1, 3'b011, 5'b00000, 5);
        chk("rs_busy", 32'(busy), 32'h1);
        chk("rs_done", 32'(done), 32'h0);
        for (int i = 0; i < 5; i++) drive(0, 0, 3'b000, 5'b00000, 0);
        chk("rs_q", 32'(signal_q), 32'b01000);
        chk("rs_end_done", 32'(done), 32'h1);
        drive(1, 1, 3'b111, 5'b00000, 0);
        chk("z_busy", 32'(busy), 32'h0);
        chk("z_done", 32'(done), 32'h1);
        chk("z_q", 32'(signal_q), 32'b01000);
        drive(0, 0, 3'b000, 5'b00000, 0);
        chk("z_done_low", 32'(done), 32'h0);
        // burst shift-left with live serial input
        drive(0, 1, 3'b010, 5'b00000, 3);
        serial_in_lsb = 1'b1; tick();
        serial_in_lsb = 1'b0; tick();
        serial_in_lsb = 1'b1; tick();
        chk("live_q", 32'(signal_q), 32'b00101);
        chk("live_done", 32'(done), 32'h1);
        // abort after two of seven steps
        drive(1, 0, 3'b101, 5'b00001, 0);
        drive(0, 1, 3'b100, 5'b00000, 7);
        drive(0, 0, 3'b000, 5'b00000, 0);
        tick();
        chk("ab_q2", 32'(signal_q), 32'b00100);
        pulse_clear("abort");
        drive(0, 1, 3'b101, 5'b10101, 1);
        chk("nb_busy", 32'(busy), 32'h1);
        drive(0, 0, 3'b000, 5'b00000, 0);
        chk("nb_q", 32'(signal_q), 32'b10101);
        chk("nb_done", 32'(done), 32'h1);
        tick();
        chk("nb_done_low", 32'(done), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
